// File: rtl/dram_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU datapath and the host loader.
// Every access is a fixed IDLE -> ACCESS -> DONE sequence with alternating priority on ties.
module dram_port_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 11,
    parameter int DATA_BUS_WIDTH    = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_read_not_write,
    input  logic [ADDRESS_BUS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_BUS_WIDTH-1:0]    cpu_rdata,
    output logic                         cpu_ack,
    output logic                         cpu_stall,
    input  logic                         host_req,
    input  logic                         host_read_not_write,
    input  logic [ADDRESS_BUS_WIDTH-1:0] host_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    host_wdata,
    output logic [DATA_BUS_WIDTH-1:0]    host_rdata,
    output logic                         host_ack,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
    output logic [DATA_BUS_WIDTH-1:0]    mem_write_data,
    input  logic [DATA_BUS_WIDTH-1:0]    mem_read_data,
    output logic                         mem_read_not_write,
    output logic                         mem_cs,
    output logic                         busy,
    output logic                         grant_owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                        state;
    state_t                        next_state;
    logic                          last_grant;
    logic                          owner;
    logic                          lat_rnw;
    logic [ADDRESS_BUS_WIDTH-1:0]  lat_addr;
    logic [DATA_BUS_WIDTH-1:0]     lat_wdata;
    logic [DATA_BUS_WIDTH-1:0]     cpu_rdata_q;
    logic [DATA_BUS_WIDTH-1:0]     host_rdata_q;
    logic                          any_req;
    logic                          pick_host;

    // On a tie the port that did not win last time goes first.
    assign any_req   = cpu_req | host_req;
    assign pick_host = host_req & (~cpu_req | ~last_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            lat_rnw      <= 1'b1;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && any_req) begin
                owner      <= pick_host;
                last_grant <= pick_host;
                lat_rnw    <= pick_host ? host_read_not_write : cpu_read_not_write;
                lat_addr   <= pick_host ? host_addr : cpu_addr;
                lat_wdata  <= pick_host ? host_wdata : cpu_wdata;
            end
            if (state == DONE && lat_rnw) begin
                if (owner)
                    host_rdata_q <= mem_read_data;
                else
                    cpu_rdata_q  <= mem_read_data;
            end
        end
    end

    // mem_cs and the acks decode the state register, so reset removes them at once.
    always_comb begin
        next_state         = state;
        mem_cs             = 1'b0;
        mem_read_not_write = 1'b1;
        cpu_ack            = 1'b0;
        host_ack           = 1'b0;
        cpu_rdata          = cpu_rdata_q;
        host_rdata         = host_rdata_q;
        unique case (state)
            IDLE: begin
                if (any_req)
                    next_state = ACCESS;
            end
            ACCESS: begin
                mem_cs             = 1'b1;
                mem_read_not_write = lat_rnw;
                next_state         = DONE;
            end
            DONE: begin
                cpu_ack    = ~owner;
                host_ack   = owner;
                // Read data is only valid this cycle, so forward it alongside the ack.
                if (lat_rnw) begin
                    if (owner)
                        host_rdata = mem_read_data;
                    else
                        cpu_rdata  = mem_read_data;
                end
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign mem_address    = lat_addr;
    assign mem_write_data = lat_wdata;
    assign busy           = (state != IDLE);
    assign grant_owner    = owner;
    assign cpu_stall      = cpu_req & ~cpu_ack;

endmodule
